// File: rtl/mc_pkg.sv
// Shared types for the multicycle controller: FSM states, ALU opcodes, ARM condition codes.
// Also holds the data-processing decode helper used by the top.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_MVN = 4'b0101;
    localparam logic [3:0] ALU_ROR = 4'b1001;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic       supported;
        logic       is_cmp;
        logic       cv_upd;    // arithmetic ops also own C and V
    } alu_dec_t;

    function automatic alu_dec_t alu_decode(input logic [5:0] funct, input logic [1:0] sh);
        alu_dec_t d;
        d = '0;
        case (funct[4:1])
            4'b0000: begin d.alu_ctrl = ALU_AND; d.supported = 1'b1; end
            4'b0001: begin d.alu_ctrl = ALU_XOR; d.supported = 1'b1; end
            4'b0010: begin d.alu_ctrl = ALU_SUB; d.supported = 1'b1; d.cv_upd = 1'b1; end
            4'b0100: begin d.alu_ctrl = ALU_ADD; d.supported = 1'b1; d.cv_upd = 1'b1; end
            4'b1100: begin d.alu_ctrl = ALU_ORR; d.supported = 1'b1; end
            4'b1111: begin d.alu_ctrl = ALU_MVN; d.supported = 1'b1; end
            4'b1101: if (sh == 2'b11) begin d.alu_ctrl = ALU_ROR; d.supported = 1'b1; end
            4'b1010: if (funct[0]) begin
                d.alu_ctrl = ALU_SUB; d.supported = 1'b1; d.is_cmp = 1'b1; d.cv_upd = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_cond_unit.sv
// Stored NZCV flags and ARM condition evaluation against them.
// Latency: flags load on the clock edge ending the write-enable cycle; no backpressure.
module cond_unit
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic       nz_we_i,
    input  logic       cv_we_i,
    output logic       cond_ex_o
);

    logic [3:0] flags_q, flags_d;
    logic       n, z, c, v;

    always_comb begin
        flags_d = flags_q;
        if (nz_we_i) flags_d[3:2] = alu_flags_i[3:2];
        if (cv_we_i) flags_d[1:0] = alu_flags_i[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) flags_q <= '0;
        else       flags_q <= flags_d;
    end

    assign {n, z, c, v} = flags_q;

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = ~z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = ~c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = ~n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = ~v;
            COND_HI: cond_ex_o = c & ~z;
            COND_LS: cond_ex_o = ~c | z;
            COND_GE: cond_ex_o = (n == v);
            COND_LT: cond_ex_o = (n != v);
            COND_GT: cond_ex_o = ~z & (n == v);
            COND_LE: cond_ex_o = z | (n != v);
            COND_AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM-subset control FSM (Moore); MC_STALL_EN adds mem_ready stalls in memory states.
// Latency: DP 4, LDR 5, STR 4, B 3, Op=11 2 cycles; stalls extend FETCH/MEMREAD/MEMWRITE only.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
`ifdef MC_STALL_EN
    input  logic       mem_ready,
`endif
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [1:0] sh,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] ALUControl,
    output logic [3:0] state_o
);

    state_t   state_q, state_d;
    alu_dec_t dec;
    logic     cond_ex, nz_we, cv_we, mem_rdy;

`ifdef MC_STALL_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    assign dec = alu_decode(Funct, sh);

    cond_unit u_cond (
        .clk         (clk),
        .reset       (reset),
        .cond_i      (Cond),
        .alu_flags_i (ALUFlags),
        .nz_we_i     (nz_we),
        .cv_we_i     (cv_we),
        .cond_ex_o   (cond_ex)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        ALUControl = ALU_ADD;
        nz_we      = 1'b0;
        cv_we      = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_rdy) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   begin ImmSrc = 2'b01; RegSrc = 2'b10; state_d = S_MEMADR; end
                    2'b10:   begin ImmSrc = 2'b10; RegSrc = 2'b01; state_d = S_BRANCH; end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_ex;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                if (mem_rdy) begin
                    MemWrite = cond_ex;
                    state_d  = S_FETCH;
                end
            end
            S_EXECUTER, S_EXECUTEI: begin
                ALUSrcB    = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
                ALUControl = dec.alu_ctrl;
                nz_we      = Funct[0] & cond_ex & dec.supported;
                cv_we      = nz_we & dec.cv_upd;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                ALUControl = dec.alu_ctrl;
                RegWrite   = cond_ex & ~dec.is_cmp & dec.supported;
                PCWrite    = RegWrite & (Rd == 4'b1111);
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // The instruction in flight is abandoned: nothing architectural may commit.
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            nz_we    = 1'b0;
            cv_we    = 1'b0;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction cycle traces built from the ARM multicycle rules,
// queued on a scoreboard and compared every cycle by an independent monitor.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op, sh;
    logic [5:0] Funct;
    logic [3:0] Rd, Cond, ALUFlags;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [3:0] ALUControl, state_o;
`ifdef MC_STALL_EN
    logic       mem_ready;
`endif

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
`ifdef MC_STALL_EN
        .mem_ready  (mem_ready),
`endif
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .sh         (sh),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ResultSrc  (ResultSrc),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .state_o    (state_o)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, mw, irw, rw, srca;
        logic [1:0] res, srcb, imm, rsrc;
        logic [3:0] aluc;
    } rec_t;

    typedef struct {
        rec_t r;
        bit   rst_only;
    } exp_t;

    exp_t       sb[$];
    rec_t       cur_steps[$];
    bit         cur_rdy[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         stall_max = 0;
    logic [3:0] mflags = 4'b0000;
    rec_t       obs;

    assign obs = {state_o, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA,
                  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Mnemonic table: code, whether it exists, whether it is CMP, whether it is arithmetic.
    function automatic logic [6:0] alu_ref(input logic [5:0] f, input logic [1:0] s);
        logic [3:0] cmd;
        cmd = f[4:1];
        if (cmd == 4'b0000) return {4'b0010, 3'b100};
        if (cmd == 4'b0001) return {4'b0100, 3'b100};
        if (cmd == 4'b0010) return {4'b0001, 3'b101};
        if (cmd == 4'b0100) return {4'b0000, 3'b101};
        if (cmd == 4'b1100) return {4'b0011, 3'b100};
        if (cmd == 4'b1111) return {4'b0101, 3'b100};
        if (cmd == 4'b1101 && s == 2'b11) return {4'b1001, 3'b100};
        if (cmd == 4'b1010 && f[0]) return {4'b0001, 3'b111};
        return 7'b0;
    endfunction

    function automatic int stall_n();
`ifdef MC_STALL_EN
        return $urandom_range(stall_max, 0);
`else
        return 0;
`endif
    endfunction

    task automatic push_step(input rec_t r, input bit mem_step);
        rec_t rs;
        int   n;
        n = mem_step ? stall_n() : 0;
        for (int k = 0; k < n; k++) begin
            rs = r;
            rs.pcw = 1'b0; rs.irw = 1'b0; rs.mw = 1'b0; rs.rw = 1'b0;
            cur_steps.push_back(rs);
            cur_rdy.push_back(1'b0);
        end
        cur_steps.push_back(r);
        cur_rdy.push_back(1'b1);
    endtask

    task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                             input logic [1:0] s, input logic [3:0] c, input logic [3:0] af,
                             input int rst_at);
        rec_t       r;
        logic [6:0] a;
        bit         ce;
        exp_t       e;
        cur_steps.delete();
        cur_rdy.delete();
        ce = cond_holds(c, mflags);
        a  = alu_ref(f, s);
        r = '0; r.st = 4'd0; r.irw = 1; r.pcw = 1; r.srca = 1; r.srcb = 2'b10; r.res = 2'b10;
        push_step(r, 1'b1);
        r = '0; r.st = 4'd1; r.srca = 1; r.srcb = 2'b10; r.res = 2'b10;
        if (op == 2'b01) begin r.imm = 2'b01; r.rsrc = 2'b10; end
        if (op == 2'b10) begin r.imm = 2'b10; r.rsrc = 2'b01; end
        push_step(r, 1'b0);
        if (op == 2'b00) begin
            r = '0; r.st = f[5] ? 4'd7 : 4'd6; r.srcb = f[5] ? 2'b01 : 2'b00; r.aluc = a[6:3];
            push_step(r, 1'b0);
            if (f[0] && ce && a[2]) begin
                mflags[3:2] = af[3:2];
                if (a[0]) mflags[1:0] = af[1:0];
            end
            r = '0; r.st = 4'd8; r.aluc = a[6:3];
            r.rw  = cond_holds(c, mflags) && !a[1] && a[2];
            r.pcw = r.rw && (rd == 4'hF);
            push_step(r, 1'b0);
        end else if (op == 2'b01) begin
            r = '0; r.st = 4'd2; r.srcb = 2'b01;
            push_step(r, 1'b0);
            if (f[0]) begin
                r = '0; r.st = 4'd3; r.adr = 1;
                push_step(r, 1'b1);
                r = '0; r.st = 4'd4; r.res = 2'b01; r.rw = ce;
                push_step(r, 1'b0);
            end else begin
                r = '0; r.st = 4'd5; r.adr = 1; r.mw = ce;
                push_step(r, 1'b1);
            end
        end else if (op == 2'b10) begin
            r = '0; r.st = 4'd9; r.srcb = 2'b01; r.res = 2'b10; r.pcw = ce;
            push_step(r, 1'b0);
        end
        for (int i = 0; i < cur_steps.size(); i++) begin
            Op = op; Funct = f; Rd = rd; sh = s; Cond = c; ALUFlags = af;
`ifdef MC_STALL_EN
            mem_ready = cur_rdy[i];
`endif
            reset = (i == rst_at);
            e.r = cur_steps[i];
            e.rst_only = (i == rst_at);
            sb.push_back(e);
            @(posedge clk); #1;
            if (i == rst_at) begin
                reset  = 1'b0;
                mflags = 4'b0000;
                break;
            end
        end
    endtask

    function automatic logic [3:0] pick_cmd(input int k);
        case (k)
            0: return 4'b0000; 1: return 4'b0001; 2: return 4'b0010; 3: return 4'b0100;
            4: return 4'b1100; 5: return 4'b1111; 6: return 4'b1101; default: return 4'b1010;
        endcase
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (e.rst_only) begin
                    if ({obs.st, obs.pcw, obs.irw, obs.mw, obs.rw} != {e.r.st, 4'b0000}) begin
                        errors++;
                        $display("FAIL reset_cycle cyc=%0d got st=%0d pcw/irw/mw/rw=%b%b%b%b exp st=%0d 0000",
                                 cyc, obs.st, obs.pcw, obs.irw, obs.mw, obs.rw, e.r.st);
                    end
                end else if (obs != e.r) begin
                    errors++;
                    $display("FAIL outputs_st%0d cyc=%0d got=%h exp=%h", e.r.st, cyc, obs, e.r);
                end
            end
        end
    end

    initial begin : driver
        exp_t       e;
        logic [5:0] f;
        logic [3:0] c, rd;
        int         ra, guard;
        reset = 1'b1; Op = '0; Funct = '0; Rd = '0; sh = '0; Cond = '0; ALUFlags = '0;
`ifdef MC_STALL_EN
        mem_ready = 1'b1;
        stall_max = 3;
`endif
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            e.r = '0; e.rst_only = 1'b1;
            sb.push_back(e);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        run_instr(2'b00, 6'b101000, 4'd1, 2'b00, 4'hE, 4'b0000, -1); // ADD R1, imm
        run_instr(2'b00, 6'b000101, 4'd2, 2'b00, 4'hE, 4'b0100, -1); // SUBS -> Z
        run_instr(2'b10, 6'b000000, 4'd0, 2'b00, 4'h0, 4'b0000, -1); // BEQ taken
        run_instr(2'b00, 6'b000101, 4'd2, 2'b00, 4'hE, 4'b0000, -1); // SUBS -> !Z
        run_instr(2'b10, 6'b000000, 4'd0, 2'b00, 4'h0, 4'b0000, -1); // BEQ not taken
        run_instr(2'b00, 6'b010101, 4'd0, 2'b00, 4'hE, 4'b1011, -1); // CMP
        run_instr(2'b10, 6'b000000, 4'd0, 2'b00, 4'hB, 4'b0000, -1); // BLT after CMP
        run_instr(2'b01, 6'b000001, 4'd3, 2'b00, 4'hE, 4'b0000, -1); // LDR
        run_instr(2'b01, 6'b000000, 4'd3, 2'b00, 4'hE, 4'b0000, -1); // STR
        run_instr(2'b00, 6'b001000, 4'hF, 2'b00, 4'hE, 4'b0000, -1); // ADD PC
        run_instr(2'b00, 6'b011010, 4'd4, 2'b11, 4'hE, 4'b0000, -1); // ROR
        run_instr(2'b00, 6'b000101, 4'd2, 2'b00, 4'hE, 4'b0100, -1); // SUBS -> Z
        run_instr(2'b00, 6'b011011, 4'd4, 2'b01, 4'hE, 4'b0000, -1); // unsupported, S set
        run_instr(2'b10, 6'b000000, 4'd0, 2'b00, 4'h0, 4'b0000, -1); // BEQ still taken
        run_instr(2'b11, 6'b111111, 4'd5, 2'b00, 4'hE, 4'b0000, -1); // Op=11
        run_instr(2'b00, 6'b001000, 4'd1, 2'b00, 4'hF, 4'b0000, -1); // never-cond ADD
        run_instr(2'b00, 6'b000101, 4'd2, 2'b00, 4'hE, 4'b0100, -1); // SUBS -> Z
        stall_max = 0;
        run_instr(2'b01, 6'b000001, 4'd3, 2'b00, 4'hE, 4'b0000, 3);  // LDR, reset in MEMREAD
        run_instr(2'b10, 6'b000000, 4'd0, 2'b00, 4'h0, 4'b0000, -1); // BEQ: flags cleared
`ifdef MC_STALL_EN
        stall_max = 3;
`endif
        for (int n = 0; n < 400; n++) begin
            f = 6'($urandom);
            if ($urandom_range(1, 0) == 1) f[4:1] = pick_cmd($urandom_range(7, 0));
            c  = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'hE;
            rd = ($urandom_range(7, 0) == 0) ? 4'hF : 4'($urandom);
            ra = ($urandom_range(15, 0) == 0) ? $urandom_range(5, 0) : -1;
            run_instr(2'($urandom), f, rd, 2'($urandom), c, 4'($urandom), ra);
        end
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
